spi_regbank_arbiter: RTL
========================

// Module: spi_regbank_arbiter
// PURPOSE
// - Owns the 4x8 device register bank and shares it between the two SPI slave front-ends
//   (SPI-clocked and sampled): requester 0 and requester 1.
// - Fair round-robin arbitration, four-phase valid/ack handshake per requester,
//   one access in flight at a time.
// - Exposes every register flat for downstream PWM/config logic.
// - Replaces the fixed-priority, unsequenced write path at top level.
// PARAMETERS
// - ADDR_W  2      register address width; bank depth = 2**ADDR_W
// - DATA_W  8      register width
// - RST_ID  8'h96  reset value of register 0; register k>0 resets to k[DATA_W-1:0]
// PORTS
// - clk          in   1                   system clock; all logic on posedge
// - rst_n        in   1                   asynchronous, active-low reset
// - req0_valid   in   1                   requester 0 access request (level, four-phase)
// - req0_we      in   1                   1 = write, 0 = read; stable while req0_valid=1
// - req0_addr    in   ADDR_W              register address; stable while req0_valid=1
// - req0_wdata   in   DATA_W              write data; stable while req0_valid=1
// - req0_ack     out  1                   access done; held until req0_valid falls
// - req0_rdata   out  DATA_W              read data (write: wdata); valid while req0_ack=1, then held
// - req1_*       as req0_*                requester 1, identical semantics
// - regs_flat    out  DATA_W*2**ADDR_W    all registers; reg k at [k*DATA_W +: DATA_W]
// - wr_strobe    out  1                   1-cycle pulse, the cycle after any register write
// BEHAVIOUR
// - Reset values (rst_n=0, async):
//   - state=IDLE, acks=0, rdata=0, wr_strobe=0, last_grant=1 (req0 wins first tie)
//   - reg0=RST_ID, regk=k
// - FSM: IDLE -> ACCESS -> ACK -> IDLE. gnt = 1-bit index of the granted requester.
// - IDLE:
//   - only req0 valid: gnt=0; only req1 valid: gnt=1
//   - both valid: gnt = ~last_grant
//   - on a grant, latch we/addr/wdata of gnt; go to ACCESS
// - ACCESS (one cycle):
//   - write: reg[addr] <= wdata, rdata_gnt <= wdata, wr_strobe=1 next cycle
//   - read: rdata_gnt <= reg[addr]
//   - last_grant <= gnt; go to ACK
// - ACK:
//   - reqN_ack=1 for gnt only
//   - stay until the granted valid samples 0, then ack=0 and go to IDLE
//   - valid already low on ACK entry: ack is high for exactly 1 cycle; the access still commits
// - Latency (no sync): valid sampled high at edge N -> reg updated and ack high after edge N+1.
// - The non-granted requester keeps valid high and waits; no request is dropped.
// - Max starvation: one access of the other requester.
// - Full address range is legal; no error path.
// - Read of the register just written by the other requester returns the new value.
// - rdata of a requester changes only in ACCESS cycles granted to that requester.
// - Reset mid-access:
//   - everything returns to reset values, including the register bank
//   - a pending write is lost; the ack is never raised
// CONFIGURATION
// - ARB_REQ_SYNC_EN defined:
//   - req0_valid and req1_valid pass through 2-flop synchronizers (reset 0) before the FSM
//   - we/addr/wdata are used unsynchronized, qualified by synced valid (stable by protocol)
//   - ack falls 2 cycles later after valid drops; request->ack latency +2 cycles
// - ARB_REQ_SYNC_EN undefined:
//   - valids drive the FSM directly; callers must already be in the clk domain
// TESTING
// - Reset: release rst_n.
//   -> regs_flat=32'h03020196, acks=0, rdata=0, wr_strobe=0.
// - Write then read (no sync): req0 write addr2 data 8'h5A.
//   -> ack0 rises 2 edges later, wr_strobe pulses once, reg2=8'h5A.
//   -> Then req1 reads addr2: rdata1=8'h5A.
// - Tie: req0 and req1 valid in the same cycle after reset.
//   -> req0 served first, then req1.
//   -> Next tie with both re-asserted: req1 first, then req0 (alternation).
// - Contention: req1 holds valid continuously while req0 issues 3 back-to-back writes.
//   -> Order 0,1,0,1,0; req1 is never skipped.
// - Early drop: req0 valid high 1 cycle only, write addr3 data 8'hC3.
//   -> reg3=8'hC3; ack0 high exactly 1 cycle; FSM back in IDLE.
// - Reset mid-access: assert rst_n low while in ACCESS (req1 write addr1 data 8'hFF).
//   -> reg1=8'h01, no ack.
//   -> With ARB_REQ_SYNC_EN: ack latency 4 edges, ack falls 2 edges after valid drops.

Source files
------------

// File: rtl/spi_regbank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_regbank_arbiter_if
// Brief    : Two-requester four-phase valid/ack register access bus.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_regbank_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ack;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ack;
    logic [DATA_W-1:0] req1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ack, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ack, req1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ack, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ack, req1_rdata
    );
endinterface
`default_nettype wire

// File: rtl/spi_regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_regbank_arbiter
// Brief    : Register bank shared by two requesters, round-robin arbitrated,
//            one access in flight. Optional ARB_REQ_SYNC_EN adds 2-flop
//            synchronizers on both request valids.
// Revision : 1.0 - initial release
// ============================================================================
module spi_regbank_arbiter #(
    parameter int                ADDR_W = 2,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] RST_ID = 8'h96
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    spi_regbank_arbiter_if.slave               bus,
    output logic [DATA_W*(2**ADDR_W)-1:0]      regs_flat,
    output logic                               wr_strobe
);
    localparam int c_depth = 2**ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_v0;
    logic              w_v1;
    logic              w_any;
    logic              w_pick;
    logic              w_gnt_valid;
    logic [DATA_W-1:0] w_access_data;

    logic              r_gnt;
    logic              r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_wr_strobe;
    logic [DATA_W-1:0] r_bank [c_depth];

`ifdef ARB_REQ_SYNC_EN
    logic [1:0] r_sync0;
    logic [1:0] r_sync1;

    // Only the valids cross domains; payload is stable while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 2'b00;
            r_sync1 <= 2'b00;
        end else begin
            r_sync0 <= {r_sync0[0], bus.req0_valid};
            r_sync1 <= {r_sync1[0], bus.req1_valid};
        end
    end

    assign w_v0 = r_sync0[1];
    assign w_v1 = r_sync1[1];
`else
    assign w_v0 = bus.req0_valid;
    assign w_v1 = bus.req1_valid;
`endif

    // On a tie, the requester not served last wins.
    assign w_any         = w_v0 | w_v1;
    assign w_pick        = (w_v0 & w_v1) ? ~r_last_grant : w_v1;
    assign w_gnt_valid   = r_gnt ? w_v1 : w_v0;
    assign w_access_data = r_we ? r_wdata : r_bank[r_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_ACCESS;
            S_ACCESS: w_next = S_ACK;
            S_ACK:    if (!w_gnt_valid) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_wr_strobe  <= 1'b0;
            for (int k = 0; k < c_depth; k++)
                r_bank[k] <= (k == 0) ? RST_ID : DATA_W'(k);
        end else begin
            r_wr_strobe <= 1'b0;
            if (r_state == S_IDLE && w_any) begin
                r_gnt   <= w_pick;
                r_we    <= w_pick ? bus.req1_we    : bus.req0_we;
                r_addr  <= w_pick ? bus.req1_addr  : bus.req0_addr;
                r_wdata <= w_pick ? bus.req1_wdata : bus.req0_wdata;
            end
            if (r_state == S_ACCESS) begin
                r_last_grant <= r_gnt;
                if (r_we) begin
                    r_bank[r_addr] <= r_wdata;
                    r_wr_strobe    <= 1'b1;
                end
                if (r_gnt) r_rdata1 <= w_access_data;
                else       r_rdata0 <= w_access_data;
            end
        end
    end

    assign bus.req0_ack   = (r_state == S_ACK) && !r_gnt;
    assign bus.req1_ack   = (r_state == S_ACK) &&  r_gnt;
    assign bus.req0_rdata = r_rdata0;
    assign bus.req1_rdata = r_rdata1;
    assign wr_strobe      = r_wr_strobe;

    generate
        for (genvar k = 0; k < c_depth; k++) begin : g_flat
            assign regs_flat[k*DATA_W +: DATA_W] = r_bank[k];
        end
    endgenerate
endmodule
`default_nettype wire
